// File: rtl/fft_stage_sequencer.sv
// Address/strobe sequencer for an in-place radix-2 256-point FFT: 8 stages of 128 butterflies.
// Optional macro FFT_SEQ_PERF_EN adds the cycle_cnt[15:0] busy-cycle counter output.
module fft_stage_sequencer #(
    parameter int BFLY_LAT = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       fft_start,
    input  logic       abort,
    output logic       rd_en,
    output logic [8:0] rd_addr_a,
    output logic [8:0] rd_addr_b,
    output logic [6:0] tw_addr,
    output logic       wr_en,
    output logic [8:0] wr_addr_a,
    output logic [8:0] wr_addr_b,
    output logic [2:0] stage,
    output logic       busy,
    output logic       fft_done,
    output logic       start_err
`ifdef FFT_SEQ_PERF_EN
    ,
    output logic [15:0] cycle_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [2:0] LAT_M1  = 3'(BFLY_LAT - 1);

    // Operand A address: group base (grp * 2 * span) plus position inside the group.
    function automatic logic [8:0] addr_a_f(input logic [6:0] k, input logic [2:0] s);
        logic [8:0] k9;
        logic [8:0] pos;
        logic [8:0] grp;
        k9  = {2'b00, k};
        pos = k9 & ((9'd1 << s) - 9'd1);
        grp = k9 >> s;
        return (grp << ({1'b0, s} + 4'd1)) | pos;
    endfunction

    function automatic logic [6:0] tw_f(input logic [6:0] k, input logic [2:0] s);
        logic [6:0] pos;
        pos = k & ((7'd1 << s) - 7'd1);
        return pos << (3'd7 - s);
    endfunction

    logic [1:0]  state_q, state_d;
    logic [2:0]  stage_q, stage_d;
    logic [6:0]  k_q, k_d;
    logic [2:0]  dcnt_q, dcnt_d;
    logic        flush_s;
    logic        rd_en_q, rd_en_d;
    logic [8:0]  rd_addr_a_q, rd_addr_a_d;
    logic [8:0]  rd_addr_b_q, rd_addr_b_d;
    logic [6:0]  tw_addr_q, tw_addr_d;
    logic        busy_q, busy_d;
    logic        fft_done_q, fft_done_d;
    logic        start_err_q, start_err_d;
    // Each delay-line entry packs {en, addr_a, addr_b}.
    logic [18:0] wpipe_q [BFLY_LAT];
    logic [18:0] wpipe_d [BFLY_LAT];

    // FSM next-state, stage/k stepping and abort handling.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        flush_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fft_start && !abort) begin
                    state_d = S_ISSUE;
                    stage_d = 3'd0;
                    k_d     = 7'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (k_q == 7'd127) begin
                    state_d = S_DRAIN;
                    dcnt_d  = LAT_M1;
                end else begin
                    k_d = k_q + 7'd1;
                end
            end
            S_DRAIN: begin
                if (dcnt_q != 3'd0) begin
                    dcnt_d = dcnt_q - 3'd1;
                end else if (stage_q == 3'd7) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                    stage_d = stage_q + 3'd1;
                    k_d     = 7'd0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                stage_d = 3'd0;
                k_d     = 7'd0;
            end
            default: begin
                state_d = S_IDLE;
                stage_d = 3'd0;
                k_d     = 7'd0;
            end
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            stage_d = 3'd0;
            k_d     = 7'd0;
            dcnt_d  = 3'd0;
            flush_s = 1'b1;
        end else begin
            flush_s = 1'b0;
        end
    end

    // Output values are derived from the next state so they register in step with it.
    always_comb begin
        rd_en_d     = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
        fft_done_d  = (state_d == S_DONE);
        start_err_d = fft_start && busy_q;
        if (rd_en_d) begin
            rd_addr_a_d = addr_a_f(k_d, stage_d);
            rd_addr_b_d = rd_addr_a_d + (9'd1 << stage_d);
            tw_addr_d   = tw_f(k_d, stage_d);
        end else begin
            rd_addr_a_d = 9'd0;
            rd_addr_b_d = 9'd0;
            tw_addr_d   = 7'd0;
        end
    end

    // Write delay line: read strobe/addresses shifted by BFLY_LAT, cleared on abort.
    always_comb begin
        wpipe_d[0] = {rd_en_q, rd_addr_a_q, rd_addr_b_q};
        for (int i = 1; i < BFLY_LAT; i++) begin
            wpipe_d[i] = wpipe_q[i-1];
        end
        if (flush_s) begin
            for (int i = 0; i < BFLY_LAT; i++) begin
                wpipe_d[i] = 19'd0;
            end
        end else begin
            wpipe_d[0] = {rd_en_q, rd_addr_a_q, rd_addr_b_q};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            stage_q     <= 3'd0;
            k_q         <= 7'd0;
            dcnt_q      <= 3'd0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= 9'd0;
            rd_addr_b_q <= 9'd0;
            tw_addr_q   <= 7'd0;
            busy_q      <= 1'b0;
            fft_done_q  <= 1'b0;
            start_err_q <= 1'b0;
            for (int i = 0; i < BFLY_LAT; i++) begin
                wpipe_q[i] <= 19'd0;
            end
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            k_q         <= k_d;
            dcnt_q      <= dcnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_addr_q   <= tw_addr_d;
            busy_q      <= busy_d;
            fft_done_q  <= fft_done_d;
            start_err_q <= start_err_d;
            for (int i = 0; i < BFLY_LAT; i++) begin
                wpipe_q[i] <= wpipe_d[i];
            end
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign tw_addr   = tw_addr_q;
    assign stage     = stage_q;
    assign busy      = busy_q;
    assign fft_done  = fft_done_q;
    assign start_err = start_err_q;
    assign wr_en     = wpipe_q[BFLY_LAT-1][18];
    assign wr_addr_a = wpipe_q[BFLY_LAT-1][17:9];
    assign wr_addr_b = wpipe_q[BFLY_LAT-1][8:0];

`ifdef FFT_SEQ_PERF_EN
    logic [15:0] cycle_cnt_q, cycle_cnt_d;

    // Busy-cycle counter: cleared on start acceptance, frozen whenever idle.
    always_comb begin
        if ((state_q == S_IDLE) && fft_start && !abort) begin
            cycle_cnt_d = 16'd0;
        end else if (busy_q) begin
            cycle_cnt_d = cycle_cnt_q + 16'd1;
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cycle_cnt_q <= 16'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: address table, timing, start_err, abort, reset and a BFLY_LAT=1 instance.
module tb_fft_stage_sequencer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start1 = 1'b0, abort1 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
    logic       rd_en1, wr_en1, busy1, fft_done1, start_err1;
    logic [8:0] rd_addr_a1, rd_addr_b1, wr_addr_a1, wr_addr_b1;
    logic [6:0] tw_addr1;
    logic [2:0] stage1;
    logic       rd_en2, wr_en2, busy2, fft_done2, start_err2;
    logic [8:0] rd_addr_a2, rd_addr_b2, wr_addr_a2, wr_addr_b2;
    logic [6:0] tw_addr2;
    logic [2:0] stage2;
`ifdef FFT_SEQ_PERF_EN
    logic [15:0] cycle_cnt1, cycle_cnt2;
`endif

    always #5 clk = ~clk;

    fft_stage_sequencer #(.BFLY_LAT(3)) dut1 (
        .clk(clk), .n_rst(n_rst), .fft_start(start1), .abort(abort1),
        .rd_en(rd_en1), .rd_addr_a(rd_addr_a1), .rd_addr_b(rd_addr_b1), .tw_addr(tw_addr1),
        .wr_en(wr_en1), .wr_addr_a(wr_addr_a1), .wr_addr_b(wr_addr_b1),
        .stage(stage1), .busy(busy1), .fft_done(fft_done1), .start_err(start_err1)
`ifdef FFT_SEQ_PERF_EN
        , .cycle_cnt(cycle_cnt1)
`endif
    );

    fft_stage_sequencer #(.BFLY_LAT(1)) dut2 (
        .clk(clk), .n_rst(n_rst), .fft_start(start2), .abort(abort2),
        .rd_en(rd_en2), .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2), .tw_addr(tw_addr2),
        .wr_en(wr_en2), .wr_addr_a(wr_addr_a2), .wr_addr_b(wr_addr_b2),
        .stage(stage2), .busy(busy2), .fft_done(fft_done2), .start_err(start_err2)
`ifdef FFT_SEQ_PERF_EN
        , .cycle_cnt(cycle_cnt2)
`endif
    );

    typedef struct {
        int stg;
        int k;
        int a;
        int b;
        int tw;
    } vec_t;

    vec_t vecs [12];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rd_a [1024], rd_b [1024], rd_tw [1024], rd_stg [1024], rd_cyc [1024];
    int   wr_a [1024], wr_b [1024], wr_cyc [1024];
    int   nrd = 0, nwr = 0, ndone = 0, nerr = 0;
    int   first_busy, first_rd, first_a, first_b, first_tw, first_stg;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every read/write strobe of dut1 (first 1024 of each kept in detail).
    always @(negedge clk) begin
        if (rd_en1) begin
            if (nrd < 1024) begin
                rd_a[nrd] = int'(rd_addr_a1); rd_b[nrd] = int'(rd_addr_b1);
                rd_tw[nrd] = int'(tw_addr1); rd_stg[nrd] = int'(stage1); rd_cyc[nrd] = cyc;
            end
            nrd++;
        end
        if (wr_en1) begin
            if (nwr < 1024) begin
                wr_a[nwr] = int'(wr_addr_a1); wr_b[nwr] = int'(wr_addr_b1); wr_cyc[nwr] = cyc;
            end
            nwr++;
        end
        if (fft_done1) ndone++;
        if (start_err1) nerr++;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start on dut1, count busy cycles up to and including fft_done.
    task automatic run1(input int err_at, output int bc, output int found);
        bc = 0;
        found = 0;
        @(negedge clk) start1 = 1'b1;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            @(negedge clk);
            start1 = (i == err_at) ? 1'b1 : 1'b0;
            if (i == 0) begin
                first_busy = int'(busy1); first_rd = int'(rd_en1); first_a = int'(rd_addr_a1);
                first_b = int'(rd_addr_b1); first_tw = int'(tw_addr1); first_stg = int'(stage1);
            end
            if (busy1) bc++;
            if (fft_done1) found = 1;
        end
        start1 = 1'b0;
    endtask

    initial begin
        int bc, found, base_done, base_err, snap_rd, snap_wr, snap_done, idx, ok, hit;

        vecs[0]  = '{0,   0,   0,   1,   0};
        vecs[1]  = '{0, 127, 254, 255,   0};
        vecs[2]  = '{1,   0,   0,   2,   0};
        vecs[3]  = '{1,   5,   9,  11,  64};
        vecs[4]  = '{2,   6,  10,  14,  64};
        vecs[5]  = '{3,  13,  21,  29,  80};
        vecs[6]  = '{4,  31,  47,  63, 120};
        vecs[7]  = '{5,  77, 141, 173,  52};
        vecs[8]  = '{6, 100, 164, 228,  72};
        vecs[9]  = '{7,   0,   0, 128,   0};
        vecs[10] = '{7, 127, 127, 255, 127};
        vecs[11] = '{7,  64,  64, 192,  64};

        // Reset state
        #12;
        check("rst_rd_en", int'(rd_en1), 0);
        check("rst_wr_en", int'(wr_en1), 0);
        check("rst_busy", int'(busy1), 0);
        check("rst_done", int'(fft_done1), 0);
        check("rst_addr", int'(rd_addr_a1) + int'(rd_addr_b1) + int'(tw_addr1) + int'(wr_addr_a1), 0);
        check("rst_stage", int'(stage1), 0);
        @(negedge clk) n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Full transform
        run1(-1, bc, found);
        check("done_seen", found, 1);
        check("busy_cycles", bc, 1049);
        check("first_busy", first_busy, 1);
        check("first_rd_en", first_rd, 1);
        check("first_a", first_a, 0);
        check("first_b", first_b, 1);
        check("first_tw", first_tw, 0);
        check("first_stage", first_stg, 0);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        check("rd_count", nrd, 1024);
        check("wr_count", nwr, 1024);
        check("done_count", ndone, 1);
        check("no_err", nerr, 0);
        check("idle_busy", int'(busy1), 0);

        // Address table against the logged reads/writes
        for (int v = 0; v < 12; v++) begin
            idx = vecs[v].stg * 128 + vecs[v].k;
            check($sformatf("v%0d_stage", v), rd_stg[idx], vecs[v].stg);
            check($sformatf("v%0d_a", v), rd_a[idx], vecs[v].a);
            check($sformatf("v%0d_b", v), rd_b[idx], vecs[v].b);
            check($sformatf("v%0d_tw", v), rd_tw[idx], vecs[v].tw);
            check($sformatf("v%0d_wa", v), wr_a[idx], vecs[v].a);
            check($sformatf("v%0d_wb", v), wr_b[idx], vecs[v].b);
            check($sformatf("v%0d_wlat", v), wr_cyc[idx] - rd_cyc[idx], 3);
        end

        // Last write of each stage lands before the next stage's first read
        ok = 1;
        for (int s = 0; s < 7; s++) begin
            if (wr_cyc[s*128+127] >= rd_cyc[(s+1)*128]) ok = 0;
        end
        check("no_raw_hazard", ok, 1);

        // Start while busy
        base_done = ndone; base_err = nerr;
        run1(500, bc, found);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        check("err_done_seen", found, 1);
        check("err_busy_cycles", bc, 1049);
        check("err_pulses", nerr - base_err, 1);
        check("err_done_count", ndone - base_done, 1);

        // Abort in stage 5 drain
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        hit = 0;
        for (int i = 0; i < 2000 && hit == 0; i++) begin
            if (stage1 == 3'd5 && busy1 && !rd_en1) hit = 1;
            else @(negedge clk);
        end
        check("drain5_found", hit, 1);
        abort1 = 1'b1;
        @(posedge clk); #1;
        abort1 = 1'b0;
        snap_rd = nrd; snap_wr = nwr; snap_done = ndone;
        @(negedge clk);
        check("abort_busy", int'(busy1), 0);
        check("abort_wr_en", int'(wr_en1), 0);
        check("abort_stage", int'(stage1), 0);
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        check("abort_no_rd", nrd - snap_rd, 0);
        check("abort_no_wr", nwr - snap_wr, 0);
        check("abort_no_done", ndone - snap_done, 0);
        run1(-1, bc, found);
        check("post_abort_done", found, 1);
        check("post_abort_cycles", bc, 1049);

        // Reset asserted mid-transform
        repeat (2) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        repeat (20) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("arst_rd_en", int'(rd_en1), 0);
        check("arst_wr_en", int'(wr_en1), 0);
        check("arst_busy", int'(busy1), 0);
        snap_wr = nwr;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        check("arst_no_wr", nwr - snap_wr, 0);

        // BFLY_LAT = 1 instance
        bc = 0; found = 0;
        @(negedge clk) start2 = 1'b1;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (busy2) bc++;
            if (fft_done2) found = 1;
        end
        check("lat1_done_seen", found, 1);
        check("lat1_busy_cycles", bc, 1033);
        @(negedge clk);
`ifdef FFT_SEQ_PERF_EN
        check("lat1_cycle_cnt", int'(cycle_cnt2), 1033);
`endif
        check("lat1_idle", int'(busy2), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 Parameter: BFLY_LAT, default 3, butterfly unit read-to-write latency in cycles; legal range 1..7.
REQ-002 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-003 Port: n_rst  in  1  asynchronous, active-low reset.
REQ-004 Port: fft_start  in  1  one-cycle request to transform the 256 samples held in sample RAM.
REQ-005 Port: abort  in  1  cancel the transform in progress.
REQ-006 Port: rd_en  out  1  sample RAM read strobe for a butterfly operand pair.
REQ-007 Port: rd_addr_a, rd_addr_b  out  9 each  operand A/B read addresses; bit 8 always 0.
REQ-008 Port: tw_addr  out  7  twiddle ROM index.
REQ-009 Port: wr_en  out  1  sample RAM write strobe for butterfly results.
REQ-010 Port: wr_addr_a, wr_addr_b  out  9 each  result write addresses.
REQ-011 Port: stage  out  3  current stage, 0..7.
REQ-012 Port: busy  out  1  high from first issue cycle through the done cycle.
REQ-013 Port: fft_done  out  1  one-cycle completion pulse.
REQ-014 Port: start_err  out  1  one-cycle pulse when fft_start is received while busy.

Function
REQ-015 FSM states are IDLE, ISSUE, DRAIN and DONE; the FSM leaves IDLE for ISSUE with stage=0 and k=0 when fft_start=1 and abort=0.
REQ-016 In ISSUE: rd_en=1 every cycle, with butterfly index k stepping 0..127 and one pair per cycle (no stalls).
REQ-017 Address rule, span=2^stage, grp=k>>stage, pos=k&(span-1): rd_addr_a=grp*2*span+pos, rd_addr_b=rd_addr_a+span, tw_addr=pos<<(7-stage).
REQ-018 All address arithmetic is unsigned 9-bit; results never exceed 255.
REQ-019 wr_en, wr_addr_a and wr_addr_b are rd_en, rd_addr_a and rd_addr_b delayed by exactly BFLY_LAT cycles through a shift register.
REQ-020 After issuing k=127 in ISSUE, the FSM enters DRAIN for exactly BFLY_LAT cycles so that the last write of the stage lands before the next stage reads (no read-after-write hazard).
REQ-021 At the end of DRAIN, if stage<7, stage increments, k clears and the FSM returns to ISSUE; if stage=7 it enters DONE.
REQ-022 DONE lasts one cycle with fft_done=1, then the FSM goes to IDLE.
REQ-023 fft_done is asserted exactly 8*(128+BFLY_LAT)+1 cycles after the edge that sampled fft_start; this is 1049 cycles at the default.
REQ-024 fft_start while busy=1 is ignored and pulses start_err in the following cycle.
REQ-025 If abort=1 in ISSUE, DRAIN or DONE: the next state is IDLE, the write delay line is flushed (wr_en=0 from the next cycle), stage and k clear, and fft_done is not asserted.
REQ-026 If abort and fft_start are both high in IDLE, abort wins and the FSM stays in IDLE.
REQ-027 In IDLE all address outputs are 0, and rd_en, wr_en and busy are 0.

Reset
REQ-028 While n_rst=0: state=IDLE, stage=0, k=0, the delay line is cleared, and every output is 0.
REQ-029 Reset asserted mid-transform takes effect immediately (asynchronously), with no write strobe after the asserting edge.

Configuration
REQ-030 Macro FFT_SEQ_PERF_EN: when defined, adds output cycle_cnt[15:0], cleared on fft_start acceptance, incremented each busy cycle, and held after done or abort; when undefined, the port and counter are absent and all other behaviour is identical.

Verification
REQ-031 Reset, then pulse fft_start -> busy rises the next cycle, stage 0 first pair a=0, b=1, tw=0; fft_done exactly 1049 cycles after start; 1024 rd_en and 1024 wr_en pulses in total.
REQ-032 Stage 3, k=13 -> rd_addr_a=21, rd_addr_b=29, tw_addr=80; the matching wr_addr pair appears 3 cycles later.
REQ-033 Last read of stage 0 (k=127: a=254, b=255) -> wr_en for 254/255 fires before the first stage-1 read (a=0, b=2).
REQ-034 fft_start pulsed at cycle 500 of a transform -> start_err for one cycle; completion timing is unchanged.
REQ-035 abort in stage 5 DRAIN -> IDLE next cycle, no further rd_en or wr_en, no fft_done; a new fft_start then completes normally.
REQ-036 With BFLY_LAT=1 and FFT_SEQ_PERF_EN defined -> fft_done at 1033 cycles and cycle_cnt=1033.
